// File: rtl/plot_pixel_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plotter_pkg                                                          |
// | Shared types and default geometry for the plotter pixel pipeline     |
// | (sequencer and plotter controller).                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package plotter_pkg;

  // Default image geometry; must match the plotter row capacity.
  localparam int IMG_W_DEF    = 72;
  localparam int IMG_H_DEF    = 96;
  localparam int PIX_BITS_DEF = 8;
  localparam int BRAM_LAT_DEF = 2;
  localparam int ADDR_W_DEF   = 13;

  // Row index width exposed for debug LEDs.
  localparam int ROW_W = 7;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_PRIME = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_t;

  // Width of a down-counter that has to hold lat-1.
  function automatic int lat_cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage
`default_nettype wire

// File: rtl/plot_pixel_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plot_pixel_sequencer_if                                              |
// | Control, frame-BRAM read and plotter handshake signals of the pixel  |
// | sequencer. slave = sequencer side, master = environment side.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface plot_pixel_sequencer_if
  import plotter_pkg::*;
#(
  parameter int PIX_BITS = PIX_BITS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) ();

  logic                start;
  logic [PIX_BITS-1:0] threshold;
  logic [ADDR_W-1:0]   bram_addr;
  logic [PIX_BITS-1:0] bram_data;
  logic                ready_next_pixel;
  logic                pixel_value_out;
  logic                busy;
  logic                done;
  logic                underrun;
  logic [ROW_W-1:0]    row_idx;

  modport slave (
    input  start, threshold, bram_data, ready_next_pixel,
    output bram_addr, pixel_value_out, busy, done, underrun, row_idx
  );

  modport master (
    output start, threshold, bram_data, ready_next_pixel,
    input  bram_addr, pixel_value_out, busy, done, underrun, row_idx
  );

endinterface
`default_nettype wire

// File: rtl/plot_pixel_sequencer_raster_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raster_addr_gen                                                      |
// | Raster-order pixel index: column/row counters plus a row base        |
// | accumulator (+IMG_W per row) so no multiplier is needed.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module raster_addr_gen #(
  parameter int IMG_W  = 72,
  parameter int IMG_H  = 96,
  parameter int ADDR_W = 13,
  parameter int ROW_W  = 7
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  row,
  output logic              last
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] base;
  logic              row_end;

  assign row_end = (col == COL_W'(IMG_W - 1));
  assign last    = row_end && (row == ROW_W'(IMG_H - 1));

  // Step the index; addr is kept registered as base + col.
  always_ff @(posedge clk_100mhz) begin
    if (rst || clear) begin
      col  <= '0;
      row  <= '0;
      base <= '0;
      addr <= '0;
    end else if (advance) begin
      if (row_end) begin
        col  <= '0;
        row  <= row + ROW_W'(1);
        base <= base + ADDR_W'(IMG_W);
        addr <= base + ADDR_W'(IMG_W);
      end else begin
        col  <= col + COL_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/plot_pixel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plot_pixel_sequencer                                                 |
// | Streams a greyscale frame from BRAM in raster order, thresholds each |
// | sample to ink/blank and hands one pixel to the plotter per rising    |
// | edge of ready_next_pixel, keeping one pixel prefetched.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module plot_pixel_sequencer
  import plotter_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int PIX_BITS = PIX_BITS_DEF,
  parameter int BRAM_LAT = BRAM_LAT_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                 clk_100mhz,
  input  logic                 rst,
  plot_pixel_sequencer_if.slave bus
);

  localparam int CNT_W = lat_cnt_width(BRAM_LAT);

  seq_state_t          state;
  logic                ready_q;
  logic                start_q;
  logic                in_flight;
  logic [CNT_W-1:0]    wait_cnt;
  logic                fetch_exhausted;
  logic                cur;
  logic                nxt;
  logic                nxt_valid;
  logic                busy;
  logic                done;
  logic                underrun;

  logic                consume;
  logic                start_edge;
  logic                start_go;
  logic                run_consume;
  logic                fetch_cplt;
  logic                slot_ok;
  logic                issue;
  logic                ink;
  logic [PIX_BITS-1:0] sample;

  logic [ADDR_W-1:0]   fetch_addr;
  logic [ROW_W-1:0]    fetch_row;
  logic                fetch_last;
  logic [ADDR_W-1:0]   pres_addr;
  logic [ROW_W-1:0]    pres_row;
  logic                pres_last;
  logic                unused_bits;

  assign consume     = bus.ready_next_pixel & ~ready_q;
  assign start_edge  = bus.start & ~start_q;
  assign start_go    = start_edge && (state == SEQ_IDLE || state == SEQ_DONE);
  assign run_consume = consume && (state == SEQ_RUN);
  assign fetch_cplt  = in_flight && (wait_cnt == '0);
  assign sample      = bus.bram_data;
  assign ink         = (sample < bus.threshold);
  assign unused_bits = ^{pres_addr, fetch_row};

  // Decide whether a new read can go out: one read outstanding, and the
  // result must have somewhere to land once the current one is placed.
  always_comb begin
    slot_ok = 1'b0;
    case (state)
      SEQ_PRIME: slot_ok = 1'b1;
      SEQ_RUN:   slot_ok = run_consume ? !pres_last : (!nxt_valid && !fetch_cplt);
      default:   slot_ok = 1'b0;
    endcase
    issue = slot_ok && (!in_flight || fetch_cplt) && !fetch_exhausted;
  end

  raster_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) u_fetch_idx (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clear      (start_go),
    .advance    (issue),
    .addr       (fetch_addr),
    .row        (fetch_row),
    .last       (fetch_last)
  );

  raster_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) u_pres_idx (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clear      (start_go),
    .advance    (run_consume),
    .addr       (pres_addr),
    .row        (pres_row),
    .last       (pres_last)
  );

  // Sequencer FSM with fetch engine, edge history and registered outputs.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state           <= SEQ_IDLE;
      ready_q         <= 1'b0;
      start_q         <= 1'b0;
      in_flight       <= 1'b0;
      wait_cnt        <= '0;
      fetch_exhausted <= 1'b0;
      cur             <= 1'b0;
      nxt             <= 1'b0;
      nxt_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      ready_q <= bus.ready_next_pixel;
      start_q <= bus.start;

      if (issue) begin
        in_flight <= 1'b1;
        wait_cnt  <= CNT_W'(BRAM_LAT - 1);
        if (fetch_last) fetch_exhausted <= 1'b1;
      end else if (fetch_cplt) begin
        in_flight <= 1'b0;
      end else if (in_flight) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end

      case (state)
        SEQ_IDLE, SEQ_DONE: begin
          // A restart also drops any read still in flight from a prior image.
          if (start_edge) begin
            state           <= SEQ_PRIME;
            busy            <= 1'b1;
            done            <= 1'b0;
            underrun        <= 1'b0;
            cur             <= 1'b0;
            nxt             <= 1'b0;
            nxt_valid       <= 1'b0;
            in_flight       <= 1'b0;
            fetch_exhausted <= 1'b0;
          end
        end
        SEQ_PRIME: begin
          if (fetch_cplt) begin
            cur   <= ink;
            state <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (consume) begin
            if (pres_last) begin
              state     <= SEQ_DONE;
              cur       <= 1'b0;
              nxt_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (nxt_valid) begin
              cur       <= nxt;
              nxt_valid <= 1'b0;
            end else if (fetch_cplt) begin
              cur <= ink;
            end else begin
              cur      <= 1'b0;
              underrun <= 1'b1;
            end
          end else if (fetch_cplt) begin
            nxt       <= ink;
            nxt_valid <= 1'b1;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

  assign bus.bram_addr       = fetch_addr;
  assign bus.pixel_value_out = cur;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.underrun        = underrun;
  assign bus.row_idx         = pres_row;

endmodule
`default_nettype wire
